// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into padded 512-bit blocks.
// Optional `SHA256_PAD_PROTO_CHK_EN adds a sticky proto_err output for illegal in_bytes usage.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_bytes,
  input  logic        in_last,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [31:0] blk_data [16],
  output logic        blk_first,
  output logic        blk_last
`ifdef SHA256_PAD_PROTO_CHK_EN
  ,
  output logic        proto_err
`endif
);

  typedef enum logic [2:0] {FILL, PAD, LEN_HI, LEN_LO, EMIT} state_t;

  state_t           state, state_nxt, ret_state;
  logic [3:0]       idx;
  logic [LEN_W-1:0] bit_cnt;
  logic [63:0]      len64;
  logic [31:0]      blk_buf [16];
  logic             marker_pending;
  logic             first_pending;
  logic             last_q;
  logic             accept;
  logic [2:0]       eff_bytes;
  logic             pad_done;

  // Keep the n leading message bytes, put the 0x80 marker right after them.
  function automatic logic [31:0] tail_word(input logic [31:0] data, input logic [2:0] n);
    case (n)
      3'd0:    tail_word = 32'h8000_0000;
      3'd1:    tail_word = {data[31:24], 24'h80_0000};
      3'd2:    tail_word = {data[31:16], 16'h8000};
      3'd3:    tail_word = {data[31:8], 8'h80};
      default: tail_word = data;
    endcase
  endfunction

  assign accept    = in_valid & in_ready;
  assign eff_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign len64     = 64'(bit_cnt);
  assign pad_done  = (idx == 4'd14) && !marker_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (accept) begin
          if (idx == 4'd15) state_nxt = EMIT;
          else if (in_last) state_nxt = PAD;
        end
      end
      PAD: begin
        if (pad_done)           state_nxt = LEN_HI;
        else if (idx == 4'd15)  state_nxt = EMIT;
      end
      LEN_HI:  state_nxt = LEN_LO;
      LEN_LO:  state_nxt = EMIT;
      EMIT: begin
        if (blk_ready) state_nxt = last_q ? FILL : ret_state;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    blk_valid = (state == EMIT);
    blk_first = first_pending && (state == EMIT);
    blk_last  = last_q;
    blk_data  = blk_buf;
  end

  // Buffer, counters and block-tracking flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx            <= 4'd0;
      bit_cnt        <= '0;
      marker_pending <= 1'b0;
      first_pending  <= 1'b1;
      last_q         <= 1'b0;
      ret_state      <= FILL;
      for (int i = 0; i < 16; i++) blk_buf[i] <= 32'h0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            blk_buf[idx] <= in_last ? tail_word(in_data, eff_bytes) : in_data;
            bit_cnt      <= bit_cnt + LEN_W'({eff_bytes, 3'b000});
            idx          <= idx + 4'd1;
            if (in_last && (eff_bytes == 3'd4)) marker_pending <= 1'b1;
            if (idx == 4'd15) ret_state <= in_last ? PAD : FILL;
          end
        end
        PAD: begin
          if (!pad_done) begin
            blk_buf[idx]   <= marker_pending ? 32'h8000_0000 : 32'h0;
            marker_pending <= 1'b0;
            idx            <= idx + 4'd1;
            if (idx == 4'd15) ret_state <= PAD;
          end
        end
        LEN_HI: blk_buf[14] <= len64[63:32];
        LEN_LO: begin
          blk_buf[15] <= len64[31:0];
          last_q      <= 1'b1;
        end
        EMIT: begin
          if (blk_ready) begin
            idx           <= 4'd0;
            first_pending <= 1'b0;
            if (last_q) begin
              bit_cnt       <= '0;
              first_pending <= 1'b1;
              last_q        <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_PAD_PROTO_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      proto_err <= 1'b0;
    else if (accept && ((in_bytes > 3'd4) || ((in_bytes < 3'd4) && !in_last)))
      proto_err <= 1'b1;
  end
`endif

endmodule
